// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register writeback stage: bus widths, queue depth
// and the {addr,data} layout of one pending register write.
package reg_writeback_pkg;

  localparam int DATA_BUS_WIDTH    = 24;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int WB_ENTRY_BITS     = REGFILE_ADDR_BITS + DATA_BUS_WIDTH;
  localparam int WB_DEPTH          = 4;

  // One pending register write, addr in the upper bits.
  typedef struct packed {
    logic [REGFILE_ADDR_BITS-1:0] addr;
    logic [DATA_BUS_WIDTH-1:0]    data;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(input logic [REGFILE_ADDR_BITS-1:0] addr,
                                           input logic [DATA_BUS_WIDTH-1:0]    data);
    wb_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Circular buffer taking up to two pushes and one pop per cycle.
// push0 is always stored ahead of push1 so that slot order equals program order.
// The raw entry array and read pointer are exported so the parent can search
// pending writes; only the count oldest entries starting at rd_ptr are live.
module reg_writeback_wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0_i,
  input  wb_entry_t        entry0_i,
  input  logic             push1_i,
  input  wb_entry_t        entry1_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output wb_entry_t        entries_o [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot1;
  logic [1:0]       n_push;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    n_push   = {1'b0, push0_i} + {1'b0, push1_i};
    slot1    = push0_i ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = pop_i ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop_i);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents outside the live window are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= entry0_i;
    if (push1_i) mem_q[slot1]    <= entry1_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage in front of the register file.
// Load and ALU results arrive on valid/ready ports and are queued, then drained
// one per cycle into the regfile write port (which commits on the following negedge).
// Handshake: a result transfers on a posedge where valid && ready; ready depends only
// on the registered queue count (and, for ALU, on ld_valid) and never on this cycle's drain.
// Optional feature macro WB_BYPASS_EN: when defined, byp_hit/byp_data return the
// youngest pending value for byp_addr; when undefined they are tied to 0.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [REGFILE_ADDR_BITS-1:0] ld_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    ld_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REGFILE_ADDR_BITS-1:0] alu_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    alu_data,
  input  logic                         wb_hold,
  output logic                         write_enable,
  output logic [REGFILE_ADDR_BITS-1:0] write_addr,
  output logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic                         wb_busy,
  input  logic [REGFILE_ADDR_BITS-1:0] byp_addr,
  output logic                         byp_hit,
  output logic [DATA_BUS_WIDTH-1:0]    byp_data
);

  logic [CNT_W-1:0]             count;
  logic [PTR_W-1:0]             rd_ptr;
  wb_entry_t                    head;
  wb_entry_t                    entries [DEPTH];
  logic                         ld_push, alu_push, pop;
  logic                         we_q;
  logic [REGFILE_ADDR_BITS-1:0] addr_q;
  logic [DATA_BUS_WIDTH-1:0]    data_q;

  // Readiness, r0 filter and drain decision. An r0 result still handshakes but is
  // never queued because the regfile hardwires r0. ALU only gets the last free slot
  // when no load competes for it.
  always_comb begin
    ld_ready  = (count <= CNT_W'(DEPTH - 1));
    alu_ready = (count <= CNT_W'(DEPTH - 2)) ||
                (!ld_valid && (count <= CNT_W'(DEPTH - 1)));
    ld_push   = ld_valid  && ld_ready  && (ld_addr  != '0);
    alu_push  = alu_valid && alu_ready && (alu_addr != '0);
    pop       = !wb_hold && (count != '0);
  end

  reg_writeback_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0_i   (ld_push),
    .entry0_i  (make_entry(ld_addr, ld_data)),
    .push1_i   (alu_push),
    .entry1_i  (make_entry(alu_addr, alu_data)),
    .pop_i     (pop),
    .head_o    (head),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count),
    .entries_o (entries)
  );

  // Regfile write-port register: pulses write_enable on a pop, otherwise holds addr/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        addr_q <= head.addr;
        data_q <= head.data;
      end
    end
  end

  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;
  assign wb_busy      = (count != '0) || we_q;

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] idx;

  // Youngest-match search: the in-flight write is oldest, then queue entries from
  // head to tail, so a later match overrides an earlier one.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    if (byp_addr != '0) begin
      if (we_q && (addr_q == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = data_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PTR_W'(k);
        if ((k < int'(count)) && (entries[idx].addr == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = entries[idx].data;
        end
      end
    end
  end
`else
  logic unused_byp;

  // No bypass: consumers stall on wb_busy. Fold the search inputs into a sink.
  always_comb begin
    unused_byp = (^byp_addr) ^ (^rd_ptr);
    for (int k = 0; k < DEPTH; k++) begin
      unused_byp = unused_byp ^ (^entries[k]);
    end
  end

  assign byp_hit  = 1'b0;
  assign byp_data = '0;
`endif

endmodule
